wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: INSTRET_W, 64, width of retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  MEM stage presents an instruction this cycle.
REQ-005 flush  in  1  discard the instruction presented this cycle.
REQ-006 in_rd  in  5  destination register index.
REQ-007 in_rd_we  in  1  instruction writes a destination register.
REQ-008 in_wb_sel  in  2  result source: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU).
REQ-009 in_alu_result  in  32  ALU result; bits [1:0] are the load byte offset when in_wb_sel=1.
REQ-010 in_pc_plus4  in  32  link value.
REQ-011 in_funct3  in  3  load type.
REQ-012 in_mem_rdata  in  32  data-memory word, valid in the same cycle as in_valid.
REQ-013 w_en  out  1  register-file write enable.
REQ-014 rd  out  5  register-file write index.
REQ-015 rd_data  out  32  register-file write data.
REQ-016 fwd_valid / fwd_rd / fwd_data  out  1/5/32  bypass to decode: equal to w_en/rd/rd_data.
REQ-017 load_misalign  out  1  one-cycle pulse: misaligned load dropped.
REQ-018 instret  out  INSTRET_W  count of retired instructions.

Function
REQ-019 Accept = in_valid & ~flush; no backpressure, every accepted instruction retires or faults.
REQ-020 Latency is exactly 1 cycle: fields accepted at edge N drive w_en/rd/rd_data from edge N until edge N+1; all outputs are flop outputs.
REQ-021 Write data selected and formatted before the register, never after.
REQ-022 Load formatting by in_funct3 and offset o=in_alu_result[1:0]: 000 LB sign-extends byte o; 100 LBU zero-extends byte o; 001 LH sign-extends halfword o[1]; 101 LHU zero-extends halfword o[1]; 010 LW passes the word; 011/110/111 treated as LW.
REQ-023 Byte 0 is in_mem_rdata[7:0] (little-endian).
REQ-024 Misaligned: halfword with o[0]=1, or word with o!=0: w_en=0 next cycle, load_misalign=1 for that cycle, instret not incremented.
REQ-025 w_en = accepted & in_rd_we & (in_rd!=0) & ~misaligned; x0 is never written.
REQ-026 A non-misaligned accepted instruction increments instret by 1, including in_rd_we=0 and in_rd=0 cases.
REQ-027 instret wraps from all-ones to 0 without flagging.
REQ-028 Cycle without accept: w_en=0, load_misalign=0; rd and rd_data hold their previous values.
REQ-029 flush affects only the same-cycle input; an instruction already registered still writes.
REQ-030 Back-to-back accepts to the same rd produce consecutive writes; fwd_* always mirrors the current register-file write so decode can bypass the write-at-edge hazard.

Reset
REQ-031 While rst_n=0: w_en=0, rd=0, rd_data=0, load_misalign=0, instret=0, fwd_valid=0.
REQ-032 Reset mid-operation discards the registered instruction; no write occurs on or after the reset edge until a new accept.
REQ-033 The first accept after rst_n rises is registered on the first rising clk edge at which rst_n=1.

Structure
REQ-034 The wb_sel codes and load funct3 codes are defined in the shared defines package, not locally.
REQ-035 Load extraction/extension and misalignment detection live in one combinational sub-module, load_align.
REQ-036 No memories; state is the output register set plus instret.

Verification
REQ-037 LB, rdata=0x8081_8283, o=1, rd=5 -> next cycle w_en=1, rd=5, rd_data=0xFFFF_FF82; LBU same -> 0x0000_0082.
REQ-038 LH, o=2, rdata=0x8001_1234, rd=7 -> rd_data=0xFFFF_8001; LW with o=2 -> w_en=0, load_misalign=1, instret unchanged.
REQ-039 ALU, result 0x1234_5678, rd=0, in_rd_we=1 -> w_en=0, instret +1; same with rd=3 -> w_en=1, rd_data=0x1234_5678, fwd_* equal.
REQ-040 in_valid=1 with flush=1, JAL rd=1, pc_plus4=0x100 -> no write, instret unchanged; repeated without flush -> rd_data=0x100.
REQ-041 Reset asserted between edges while an instruction is registered -> w_en and instret drop to 0 immediately; preload instret to all-ones (INSTRET_W=4, 15), retire one -> 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: result-source select and load funct3 codes.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: picks byte/halfword/word from the memory word,
// extends it, and flags misaligned halfword/word accesses.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_rdata >> {i_offset, 3'b000});
    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Unlisted funct3 codes fall into the word path.
    always_comb begin
        o_data     = i_rdata;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_data = {24'h0, w_byte};
            F3_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_offset[0];
            end
            F3_LHU: begin
                o_data     = {16'h0, w_half};
                o_misalign = i_offset[0];
            end
            default: o_misalign = (i_offset != 2'b00);
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-cycle registered register-file write, decode bypass,
// misaligned-load drop and retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 flush,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_we,
    input  logic [1:0]           in_wb_sel,
    input  logic [31:0]          in_alu_result,
    input  logic [31:0]          in_pc_plus4,
    input  logic [2:0]           in_funct3,
    input  logic [31:0]          in_mem_rdata,
    output logic                 w_en,
    output logic [4:0]           rd,
    output logic [31:0]          rd_data,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [31:0]          fwd_data,
    output logic                 load_misalign,
    output logic [INSTRET_W-1:0] instret
);

    logic                 w_accept;
    logic                 w_misalign;
    logic                 w_retire;
    logic                 w_load_mis;
    logic [31:0]          w_load_data;
    logic [31:0]          w_data;

    logic                 r_wen;
    logic [4:0]           r_rd;
    logic [31:0]          r_data;
    logic                 r_misalign;
    logic [INSTRET_W-1:0] r_instret;

    load_align u_load_align (
        .i_rdata    (in_mem_rdata),
        .i_offset   (in_alu_result[1:0]),
        .i_funct3   (in_funct3),
        .o_data     (w_load_data),
        .o_misalign (w_load_mis)
    );

    assign w_accept   = in_valid & ~flush;
    assign w_misalign = w_accept & (in_wb_sel == WB_LOAD) & w_load_mis;
    assign w_retire   = w_accept & ~w_misalign;

    always_comb begin
        w_data = in_alu_result;
        case (wb_sel_e'(in_wb_sel))
            WB_LOAD: w_data = w_load_data;
            WB_PC4:  w_data = in_pc_plus4;
            default: w_data = in_alu_result;
        endcase
    end

    // rd/rd_data only move on a retiring accept so idle cycles hold the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen      <= 1'b0;
            r_rd       <= '0;
            r_data     <= '0;
            r_misalign <= 1'b0;
            r_instret  <= '0;
        end else begin
            r_wen      <= w_retire & in_rd_we & (in_rd != 5'd0);
            r_misalign <= w_misalign;
            if (w_retire) begin
                r_rd      <= in_rd;
                r_data    <= w_data;
                r_instret <= r_instret + INSTRET_W'(1);
            end
        end
    end

    assign w_en          = r_wen;
    assign rd            = r_rd;
    assign rd_data       = r_data;
    assign fwd_valid     = r_wen;
    assign fwd_rd        = r_rd;
    assign fwd_data      = r_data;
    assign load_misalign = r_misalign;
    assign instret       = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage with a 4-bit instret so counter wrap is reachable.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic [4:0]    in_rd = '0;
    logic          in_rd_we = 1'b0;
    logic [1:0]    in_wb_sel = '0;
    logic [31:0]   in_alu_result = '0;
    logic [31:0]   in_pc_plus4 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [31:0]   in_mem_rdata = '0;
    logic          w_en;
    logic [4:0]    rd;
    logic [31:0]   rd_data;
    logic          fwd_valid;
    logic [4:0]    fwd_rd;
    logic [31:0]   fwd_data;
    logic          load_misalign;
    logic [IW-1:0] instret;

    wb_stage #(.INSTRET_W(IW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .flush         (flush),
        .in_rd         (in_rd),
        .in_rd_we      (in_rd_we),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .in_funct3     (in_funct3),
        .in_mem_rdata  (in_mem_rdata),
        .w_en          (w_en),
        .rd            (rd),
        .rd_data       (rd_data),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .load_misalign (load_misalign),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wen;
        logic [4:0]    rd;
        logic [31:0]   data;
        logic          mis;
        logic [IW-1:0] ir;
    } exp_t;

    typedef struct {
        logic        v;
        logic        f;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [31:0] md;
    } stim_t;

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [4:0]    m_rd = '0;
    logic [31:0]   m_data = '0;
    logic [IW-1:0] m_ir = '0;

    function automatic stim_t S(input logic v, input logic f, input logic [4:0] r,
                                input logic we, input logic [1:0] sel, input logic [31:0] alu,
                                input logic [31:0] pc4, input logic [2:0] f3, input logic [31:0] md);
        stim_t s;
        s.v = v; s.f = f; s.rd = r; s.we = we; s.sel = sel;
        s.alu = alu; s.pc4 = pc4; s.f3 = f3; s.md = md;
        return s;
    endfunction

    // Drive one cycle, compute the reference outcome, push it, then step past the edge.
    task automatic apply(input stim_t s);
        logic        acc;
        logic        mis;
        logic [1:0]  o;
        logic [7:0]  bt;
        logic [15:0] hw;
        logic [31:0] val;
        exp_t        e;
        in_valid = s.v; flush = s.f; in_rd = s.rd; in_rd_we = s.we; in_wb_sel = s.sel;
        in_alu_result = s.alu; in_pc_plus4 = s.pc4; in_funct3 = s.f3; in_mem_rdata = s.md;
        acc = s.v & ~s.f;
        o   = s.alu[1:0];
        mis = 1'b0;
        val = s.alu;
        if (s.sel == 2'd1) begin
            if (s.f3[1:0] == 2'd0) begin
                bt  = s.md[8*o +: 8];
                val = s.f3[2] ? {24'h0, bt} : {{24{bt[7]}}, bt};
            end else if (s.f3[1:0] == 2'd1) begin
                hw  = s.md[16*o[1] +: 16];
                val = s.f3[2] ? {16'h0, hw} : {{16{hw[15]}}, hw};
                mis = o[0];
            end else begin
                val = s.md;
                mis = (o != 2'd0);
            end
        end else if (s.sel == 2'd2) begin
            val = s.pc4;
        end
        mis   = mis & acc & (s.sel == 2'd1);
        e.wen = acc & ~mis & s.we & (s.rd != 5'd0);
        e.mis = mis;
        if (acc && !mis) begin
            m_rd   = s.rd;
            m_data = val;
            m_ir   = m_ir + 1'b1;
        end
        e.rd = m_rd; e.data = m_data; e.ir = m_ir;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_rd = '0; m_data = '0; m_ir = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_rd = 5'd3; in_rd_we = 1'b1; in_alu_result = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({w_en, rd, rd_data, load_misalign, instret, fwd_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_state got=%h want=0", {w_en, rd, rd_data, load_misalign, instret, fwd_valid});
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_loads();
        stim_t t[$];
        exp_t  e;
        t.push_back(S(1, 0, 5, 1, 1, 32'h1, 0, F3_LB,  32'h8081_8283));
        t.push_back(S(1, 0, 5, 1, 1, 32'h1, 0, F3_LBU, 32'h8081_8283));
        t.push_back(S(1, 0, 7, 1, 1, 32'h2, 0, F3_LH,  32'h8001_1234));
        t.push_back(S(1, 0, 7, 1, 1, 32'h2, 0, F3_LHU, 32'h8001_1234));
        t.push_back(S(1, 0, 8, 1, 1, 32'h2, 0, F3_LW,  32'h8001_1234));
        t.push_back(S(1, 0, 8, 1, 1, 32'h1, 0, F3_LH,  32'hFFFF_FFFF));
        t.push_back(S(1, 0, 8, 1, 1, 32'h10, 0, F3_LW, 32'hA5A5_0F0F));
        t.push_back(S(1, 0, 9, 1, 1, 32'h3, 0, F3_LB,  32'h7F00_0000));
        t.push_back(S(1, 0, 9, 1, 1, 32'h0, 0, 3'b110, 32'h1357_9BDF));
        t.push_back(S(1, 0, 9, 1, 1, 32'h3, 0, 3'b011, 32'h1357_9BDF));
        for (int i = 0; i < 40; i++)
            t.push_back(S($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 5'($urandom),
                          1'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom), $urandom));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_vec++;
            if ({w_en, rd, rd_data, load_misalign, instret} !== e) begin
                n_err++;
                $display("FAIL load[%0d] got=%h want=%h", i, {w_en, rd, rd_data, load_misalign, instret}, e);
            end
            n_vec++;
            if ({fwd_valid, fwd_rd, fwd_data} !== {e.wen, e.rd, e.data}) begin
                n_err++;
                $display("FAIL load_fwd[%0d] got=%h want=%h", i, {fwd_valid, fwd_rd, fwd_data}, {e.wen, e.rd, e.data});
            end
        end
    endtask

    task automatic test_alu_x0();
        stim_t t[$];
        exp_t  e;
        t.push_back(S(1, 0, 0, 1, 0, 32'h1234_5678, 32'h4, F3_LB, 32'h0));
        t.push_back(S(1, 0, 3, 1, 0, 32'h1234_5678, 32'h4, F3_LB, 32'h0));
        t.push_back(S(1, 0, 4, 0, 0, 32'h0BAD_0BAD, 32'h4, F3_LB, 32'h0));
        t.push_back(S(1, 0, 6, 1, 3, 32'h0000_0042, 32'h8, F3_LW, 32'hFFFF_FFFF));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_vec++;
            if ({w_en, rd, rd_data, load_misalign, instret} !== e) begin
                n_err++;
                $display("FAIL alu[%0d] got=%h want=%h", i, {w_en, rd, rd_data, load_misalign, instret}, e);
            end
            n_vec++;
            if ({fwd_valid, fwd_rd, fwd_data} !== {e.wen, e.rd, e.data}) begin
                n_err++;
                $display("FAIL alu_fwd[%0d] got=%h want=%h", i, {fwd_valid, fwd_rd, fwd_data}, {e.wen, e.rd, e.data});
            end
        end
    endtask

    task automatic test_flush();
        stim_t t[$];
        exp_t  e;
        t.push_back(S(1, 1, 1, 1, 2, 32'h0, 32'h100, F3_LB, 32'h0));
        t.push_back(S(0, 0, 2, 1, 0, 32'h5555_5555, 32'h0, F3_LB, 32'h0));
        t.push_back(S(1, 1, 2, 1, 1, 32'h2, 32'h0, F3_LW, 32'h0));
        t.push_back(S(1, 0, 1, 1, 2, 32'h0, 32'h100, F3_LB, 32'h0));
        t.push_back(S(1, 1, 2, 1, 0, 32'h7777_0000, 32'h0, F3_LB, 32'h0));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_vec++;
            if ({w_en, rd, rd_data, load_misalign, instret} !== e) begin
                n_err++;
                $display("FAIL flush[%0d] got=%h want=%h", i, {w_en, rd, rd_data, load_misalign, instret}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            apply(S(1, 0, 12, 1, 0, 32'hA000_0000 + 32'(i), 0, F3_LB, 0));
            e = exp_q.pop_front();
            n_vec++;
            if ({w_en, rd, rd_data, fwd_valid, fwd_rd, fwd_data, instret} !== {e.wen, e.rd, e.data, e.wen, e.rd, e.data, e.ir}) begin
                n_err++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, {w_en, rd, rd_data, fwd_valid, fwd_rd, fwd_data, instret},
                         {e.wen, e.rd, e.data, e.wen, e.rd, e.data, e.ir});
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        apply(S(1, 0, 9, 1, 0, 32'h0000_CAFE, 0, F3_LB, 0));
        e = exp_q.pop_front();
        n_vec++;
        if ({w_en, rd, rd_data} !== {1'b1, 5'd9, 32'h0000_CAFE}) begin
            n_err++;
            $display("FAIL pre_reset got=%h want=%h", {w_en, rd, rd_data}, {1'b1, 5'd9, 32'h0000_CAFE});
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({w_en, fwd_valid, instret, rd, rd_data} !== '0) begin
            n_err++;
            $display("FAIL async_reset got=%h want=0", {w_en, fwd_valid, instret, rd, rd_data});
        end
        in_valid = 1'b1; flush = 1'b0; in_rd = 5'd10; in_rd_we = 1'b1; in_wb_sel = 2'd0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({w_en, instret} !== '0) begin
            n_err++;
            $display("FAIL held_reset got=%h want=0", {w_en, instret});
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        apply(S(0, 0, 0, 0, 0, 0, 0, F3_LB, 0));
        e = exp_q.pop_front();
        n_vec++;
        if ({w_en, rd, rd_data, load_misalign, instret} !== e) begin
            n_err++;
            $display("FAIL post_reset got=%h want=%h", {w_en, rd, rd_data, load_misalign, instret}, e);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        for (int i = 0; i < 20 && !(i > 0 && e.ir == '0); i++) begin
            apply(S(1, 0, 0, 1, 0, 32'(i), 0, F3_LB, 0));
            e = exp_q.pop_front();
            n_vec++;
            if ({w_en, instret, load_misalign} !== {e.wen, e.ir, e.mis}) begin
                n_err++;
                $display("FAIL wrap[%0d] got=%h want=%h", i, {w_en, instret, load_misalign}, {e.wen, e.ir, e.mis});
            end
        end
        n_vec++;
        if (instret !== '0) begin
            n_err++;
            $display("FAIL wrap_zero got=%h want=0", instret);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_loads();
        test_alu_x0();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
